// File: rtl/analog_drive_pkg.sv
// Shared state type, widths and clamp helper for the analog drive ramp.
// ANALOG_DRIVE_CLAMP_EN selects whether targets are clamped to [V_MIN,V_MAX].
package analog_drive_pkg;

  localparam int STEP_W  = 8;
  localparam int TIMER_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    SETTLE
  } drive_state_e;

  function automatic real clamp_real(
    input real v,
    input real lo,
    input real hi
  );
    real r;
    r = v;
    if (v < lo) r = lo;
    if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/analog_drive_timer.sv
// Reloadable down-counter; expired is high in the cycle before the
// count would reach zero, so a load of N expires on the N-th edge.
module analog_drive_timer
  import analog_drive_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = (count == W'(1));

endmodule

// File: rtl/analog_drive_ramp.sv
// Slews a real-valued drive toward an accepted target in equal timed steps.
// Define ANALOG_DRIVE_CLAMP_EN to clamp accepted targets to [V_MIN,V_MAX].
module analog_drive_ramp
  import analog_drive_pkg::*;
#(
  parameter int  STEP_CYCLES   = 4,
  parameter int  SETTLE_CYCLES = 8,
  parameter real RESET_VALUE   = 0.0,
  parameter real V_MIN         = 0.0,
  parameter real V_MAX         = 1.8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              target_valid,
  output logic              target_ready,
  input  real               target_value,
  input  logic [STEP_W-1:0] num_steps,
  input  logic              abort,
  output real               drive_value,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              clamped
);

  localparam logic [TIMER_W-1:0] STEP_T =
    TIMER_W'(STEP_CYCLES);
  localparam logic [TIMER_W-1:0] SETTLE_T =
    TIMER_W'(SETTLE_CYCLES);

  drive_state_e        state;
  drive_state_e        state_nx;
  logic                accept;
  logic                upd;
  logic                last;
  logic                done_nx;
  logic                aborted_nx;
  logic                tmr_load;
  logic [TIMER_W-1:0]  tmr_value;
  logic                tmr_expired;
  logic [STEP_W-1:0]   steps_left;
  logic [STEP_W-1:0]   n_eff;
  real                 tgt;
  real                 tgt_in;
  real                 step;
  logic                clamp_hit;

`ifdef ANALOG_DRIVE_CLAMP_EN
  always_comb begin
    tgt_in    = clamp_real(target_value, V_MIN, V_MAX);
    clamp_hit = (tgt_in != target_value);
  end
`else
  logic unused_clamp;
  assign unused_clamp = (V_MIN > V_MAX);
  always_comb begin
    tgt_in    = target_value;
    clamp_hit = 1'b0;
  end
`endif

  assign accept = target_valid && target_ready;
  assign n_eff  = (num_steps == '0) ? STEP_W'(1) : num_steps;
  assign last   = (steps_left == STEP_W'(1));
  assign busy   = (state != IDLE);

  analog_drive_timer #(
    .W          (TIMER_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (tmr_load),
    .load_value (tmr_value),
    .expired    (tmr_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    done_nx    = 1'b0;
    aborted_nx = 1'b0;
    upd        = 1'b0;
    tmr_load   = 1'b0;
    tmr_value  = '0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx  = RAMP;
          tmr_load  = 1'b1;
          tmr_value = STEP_T;
        end
      end
      RAMP: begin
        if (abort) begin
          state_nx   = IDLE;
          done_nx    = 1'b1;
          aborted_nx = 1'b1;
        end else if (tmr_expired) begin
          upd = 1'b1;
          if (!last) begin
            tmr_load  = 1'b1;
            tmr_value = STEP_T;
          end else if (SETTLE_CYCLES == 0) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else begin
            state_nx  = SETTLE;
            tmr_load  = 1'b1;
            tmr_value = SETTLE_T;
          end
        end
      end
      SETTLE: begin
        if (abort) begin
          state_nx   = IDLE;
          done_nx    = 1'b1;
          aborted_nx = 1'b1;
        end else if (tmr_expired) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Last update lands exactly on tgt so rounding never reaches the endpoint.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drive_value  <= RESET_VALUE;
      tgt          <= RESET_VALUE;
      step         <= 0.0;
      steps_left   <= '0;
      clamped      <= 1'b0;
      target_ready <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      target_ready <= (state_nx == IDLE);
      done         <= done_nx;
      aborted      <= aborted_nx;
      if (accept) begin
        tgt        <= tgt_in;
        step       <= (tgt_in - drive_value) / real'(n_eff);
        steps_left <= n_eff;
        clamped    <= clamp_hit;
      end else if (upd) begin
        steps_left  <= steps_left - STEP_W'(1);
        drive_value <= last ? tgt : drive_value + step;
      end
    end
  end

endmodule

// File: tb/tb_analog_drive_ramp.sv
// Directed bench for analog_drive_ramp with a cycle-level reference model.
// Honours ANALOG_DRIVE_CLAMP_EN for the clamp expectations.
module tb_analog_drive_ramp;

  localparam int  STEP   = 4;
  localparam int  SETTLE = 8;
  localparam real RESETV = 0.0;
  localparam real VMIN   = 0.0;
  localparam real VMAX   = 1.8;

  logic       clk = 1'b0;
  logic       rst;
  logic       target_valid = 1'b0;
  logic       target_ready;
  real        target_value = 0.0;
  logic [7:0] num_steps = 8'd1;
  logic       abort = 1'b0;
  real        drive_value;
  logic       busy;
  logic       done;
  logic       aborted;
  logic       clamped;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  analog_drive_ramp #(
    .STEP_CYCLES   (STEP),
    .SETTLE_CYCLES (SETTLE),
    .RESET_VALUE   (RESETV),
    .V_MIN         (VMIN),
    .V_MAX         (VMAX)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .target_valid (target_valid),
    .target_ready (target_ready),
    .target_value (target_value),
    .num_steps    (num_steps),
    .abort        (abort),
    .drive_value  (drive_value),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .clamped      (clamped)
  );

  always #5 clk = ~clk;

  task automatic chk_b(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_near(input string nm, input real act, input real exp);
    real d;
    checks++;
    d = act - exp;
    if (d < 0.0) d = -d;
    if (d > 1.0e-9) begin
      errors++;
      $display("FAIL %s: got %0.12f expected %0.12f at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_exact(input string nm, input real act, input real exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0.15f expected exactly %0.15f at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: schedule derived from elapsed edges since acceptance.
  logic m_active = 1'b0;
  logic m_ready = 1'b0;
  logic m_done = 1'b0;
  logic m_ab = 1'b0;
  logic m_clamped = 1'b0;
  real  m_drive = RESETV;
  real  m_d0 = 0.0;
  real  m_tgt = 0.0;
  real  m_step = 0.0;
  int   m_k = 0;
  int   m_n = 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0;
      m_ready = 1'b0;
      m_done = 1'b0;
      m_ab = 1'b0;
      m_clamped = 1'b0;
      m_drive = RESETV;
    end else begin
      m_done = 1'b0;
      m_ab = 1'b0;
      if (m_active) begin
        m_k++;
        if (abort) begin
          m_active = 1'b0;
          m_done = 1'b1;
          m_ab = 1'b1;
        end else begin
          if (m_k % STEP == 0 && m_k / STEP <= m_n)
            m_drive = (m_k / STEP == m_n) ? m_tgt
                    : m_d0 + (m_k / STEP) * m_step;
          if (m_k == m_n * STEP + SETTLE) begin
            m_active = 1'b0;
            m_done = 1'b1;
          end
        end
      end else if (target_valid && m_ready) begin
        m_active = 1'b1;
        m_k = 0;
        m_d0 = m_drive;
        m_tgt = target_value;
`ifdef ANALOG_DRIVE_CLAMP_EN
        if (m_tgt > VMAX) m_tgt = VMAX;
        if (m_tgt < VMIN) m_tgt = VMIN;
`endif
        m_clamped = (m_tgt != target_value);
        m_n = (num_steps == 8'd0) ? 1 : int'(num_steps);
        m_step = (m_tgt - m_d0) / m_n;
      end
      m_ready = !m_active;
    end
  end

  always @(negedge clk) begin
    chk_near("cmp_drive", drive_value, m_drive);
    chk_b("cmp_ready", target_ready, m_ready);
    chk_b("cmp_busy", busy, m_active);
    chk_b("cmp_done", done, m_done);
    chk_b("cmp_aborted", aborted, m_ab);
    chk_b("cmp_clamped", clamped, m_clamped);
    if (done) done_seen++;
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic request(input real t, input int n);
    target_value = t;
    num_steps = 8'(n);
    target_valid = 1'b1;
    @(posedge clk);
    #1;
    target_valid = 1'b0;
  endtask

  task automatic ramp_basic(input string tag);
    request(1.2, 4);
    chk_b({tag, "_ready_drop"}, target_ready, 1'b0);
    chk_b({tag, "_busy_a0"}, busy, 1'b1);
    tick(4);
    chk_near({tag, "_s1"}, drive_value, 0.3);
    tick(4);
    chk_near({tag, "_s2"}, drive_value, 0.6);
    tick(4);
    chk_near({tag, "_s3"}, drive_value, 0.9);
    tick(4);
    chk_exact({tag, "_s4"}, drive_value, 1.2);
    tick(7);
    chk_b({tag, "_busy_a23"}, busy, 1'b1);
    chk_b({tag, "_nodone_a23"}, done, 1'b0);
    tick(1);
    chk_b({tag, "_done_a24"}, done, 1'b1);
    chk_b({tag, "_abort0_a24"}, aborted, 1'b0);
    chk_b({tag, "_ready_a24"}, target_ready, 1'b1);
    chk_b({tag, "_busy_a24"}, busy, 1'b0);
    tick(1);
    chk_b({tag, "_done_gone"}, done, 1'b0);
  endtask

  task automatic go_to(input string tag, input real v);
    request(v, 1);
    tick(STEP + SETTLE);
    chk_b({tag, "_done"}, done, 1'b1);
    tick(1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk_exact("rst_drive", drive_value, 0.0);
    chk_b("rst_ready", target_ready, 1'b0);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_done", done, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tick(1);
    chk_b("ready_after_rst", target_ready, 1'b1);

    ramp_basic("up");

    request(0.0, 3);
    tick(4);
    chk_near("dn_s1", drive_value, 0.8);
    tick(4);
    chk_near("dn_s2", drive_value, 0.4);
    tick(4);
    chk_exact("dn_s3", drive_value, 0.0);
    tick(8);
    chk_b("dn_done", done, 1'b1);
    chk_b("dn_ready", target_ready, 1'b1);

    request(0.5, 0);
    chk_b("n0_b2b_busy", busy, 1'b1);
    tick(4);
    chk_exact("n0_single", drive_value, 0.5);
    tick(7);
    chk_b("n0_nodone", done, 1'b0);
    tick(1);
    chk_b("n0_done", done, 1'b1);
    request(0.0, 1);
    chk_b("b2b_accept", busy, 1'b1);
    tick(4);
    chk_exact("b2b_s1", drive_value, 0.0);
    tick(8);
    chk_b("b2b_done", done, 1'b1);
    tick(1);

    request(1.0, 4);
    tick(4);
    chk_exact("ab_s1", drive_value, 0.25);
    tick(3);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk_exact("ab_freeze", drive_value, 0.25);
    chk_b("ab_done", done, 1'b1);
    chk_b("ab_aborted", aborted, 1'b1);
    chk_b("ab_ready", target_ready, 1'b1);
    chk_b("ab_busy", busy, 1'b0);
    tick(1);
    chk_b("ab_done_gone", done, 1'b0);
    chk_exact("ab_hold", drive_value, 0.25);

    request(0.95, 2);
    tick(4);
    chk_near("rs_mid", drive_value, 0.6);
    tick(1);
    #2 rst = 1'b1;
    #1;
    chk_exact("rs_async_drive", drive_value, 0.0);
    chk_b("rs_busy", busy, 1'b0);
    chk_b("rs_ready", target_ready, 1'b0);
    seen0 = done_seen;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tick(20);
    checks++;
    if (done_seen != seen0) begin
      errors++;
      $display("FAIL rs_no_done: got %0d done pulses expected 0", done_seen - seen0);
    end

    ramp_basic("post_rst");
    go_to("home", 0.0);

    request(2.5, 2);
`ifdef ANALOG_DRIVE_CLAMP_EN
    chk_b("cl_flag", clamped, 1'b1);
    tick(4);
    chk_exact("cl_s1", drive_value, 0.9);
    tick(4);
    chk_exact("cl_s2", drive_value, 1.8);
`else
    chk_b("cl_flag", clamped, 1'b0);
    tick(4);
    chk_exact("cl_s1", drive_value, 1.25);
    tick(4);
    chk_exact("cl_s2", drive_value, 2.5);
`endif
    tick(8);
    chk_b("cl_done", done, 1'b1);
    tick(1);
    request(1.0, 1);
    chk_b("cl_clear", clamped, 1'b0);
    tick(STEP + SETTLE);
    chk_exact("cl_final", drive_value, 1.0);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
